// File: rtl/laser_fb_writer_if.sv
// laser_fb_writer_if: command, framebuffer-write and status bundle for the
// rectangle-fill engine. The master side issues rectangle commands and the
// frame_start strobe. The slave side (the engine) drives the RAM write port
// and the status flags.
interface laser_fb_writer_if #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 18
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x0;
  logic [9:0]        cmd_y0;
  logic [9:0]        cmd_w;
  logic [9:0]        cmd_h;
  logic [IDX_W-1:0]  cmd_color;
  logic              frame_start;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [IDX_W-1:0]  fb_wdata;
  logic              busy;
  logic              done;
  logic              clipped;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, frame_start,
    input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done, clipped
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, frame_start,
    output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done, clipped
  );
endinterface

// File: rtl/laser_fb_writer.sv
// laser_fb_writer: rectangle-fill engine for the laser framebuffer RAM.
// Takes one rectangle command at a time, clips it to the framebuffer, and
// emits one palette-index write per cycle in row-major order.
// Optional feature macro FB_VSYNC_GATE_EN: when defined, a non-empty fill
// waits for a frame_start pulse (vertical blank) before writing, which avoids
// tearing in the scanned-out image. When undefined, filling starts right
// after setup.
module laser_fb_writer #(
  parameter int FB_W   = 480,
  parameter int FB_H   = 480,
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 18
) (
  input logic              clk,
  input logic              rst_n,
  laser_fb_writer_if.slave bus
);

  localparam logic [10:0]       FbW11 = 11'(FB_W);
  localparam logic [10:0]       FbH11 = 11'(FB_H);
  localparam logic [ADDR_W-1:0] FbWA  = ADDR_W'(FB_W);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_FILL     = 3'd2,
`ifdef FB_VSYNC_GATE_EN
    S_WAIT_VBL = 3'd4,
`endif
    S_DONE     = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;

  logic [9:0]        r_x0;
  logic [9:0]        r_y0;
  logic [9:0]        r_w;
  logic [9:0]        r_h;
  logic [IDX_W-1:0]  r_color;
  logic [10:0]       r_x;
  logic [10:0]       r_y;
  logic [10:0]       r_xEnd;
  logic [10:0]       r_yEnd;
  logic [ADDR_W-1:0] r_rowBase;
  logic              r_clipped;

  logic [10:0]       w_xSum;
  logic [10:0]       w_ySum;
  logic              w_xClamp;
  logic              w_yClamp;
  logic [10:0]       w_xEnd;
  logic [10:0]       w_yEnd;
  logic              w_empty;
  logic [ADDR_W-1:0] w_rowBase0;
  logic              w_rowEnd;
  logic              w_lastRow;

  // Clip arithmetic uses 11-bit sums so large x0+w cannot wrap below the edge.
  assign w_xSum     = {1'b0, r_x0} + {1'b0, r_w};
  assign w_ySum     = {1'b0, r_y0} + {1'b0, r_h};
  assign w_xClamp   = (w_xSum > FbW11);
  assign w_yClamp   = (w_ySum > FbH11);
  assign w_xEnd     = w_xClamp ? FbW11 : w_xSum;
  assign w_yEnd     = w_yClamp ? FbH11 : w_ySum;
  assign w_empty    = (r_w == 10'd0) || (r_h == 10'd0) ||
                      ({1'b0, r_x0} >= FbW11) || ({1'b0, r_y0} >= FbH11);
  assign w_rowBase0 = ADDR_W'(r_y0) * FbWA;
  assign w_rowEnd   = (r_x == (r_xEnd - 11'd1));
  assign w_lastRow  = (r_y == (r_yEnd - 11'd1));

  assign bus.clipped = r_clipped;

  // State register; reset returns the engine to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and all handshake/RAM outputs, decoded from the state.
  always_comb begin
    w_stateNext   = r_state;
    bus.cmd_ready = 1'b0;
    bus.fb_we     = 1'b0;
    bus.fb_addr   = '0;
    bus.fb_wdata  = '0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          w_stateNext = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_empty) begin
          w_stateNext = S_DONE;
        end else begin
`ifdef FB_VSYNC_GATE_EN
          w_stateNext = S_WAIT_VBL;
`else
          w_stateNext = S_FILL;
`endif
        end
      end
`ifdef FB_VSYNC_GATE_EN
      S_WAIT_VBL: begin
        if (bus.frame_start) begin
          w_stateNext = S_FILL;
        end
      end
`endif
      S_FILL: begin
        bus.fb_we    = 1'b1;
        bus.fb_addr  = r_rowBase + ADDR_W'(r_x);
        bus.fb_wdata = r_color;
        if (w_rowEnd && w_lastRow) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Command capture, clip setup and the x/y walk with an incremental row base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0      <= '0;
      r_y0      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_xEnd    <= '0;
      r_yEnd    <= '0;
      r_rowBase <= '0;
      r_clipped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_x0      <= bus.cmd_x0;
            r_y0      <= bus.cmd_y0;
            r_w       <= bus.cmd_w;
            r_h       <= bus.cmd_h;
            r_color   <= bus.cmd_color;
            r_clipped <= 1'b0;
          end
        end
        S_SETUP: begin
          r_xEnd    <= w_xEnd;
          r_yEnd    <= w_yEnd;
          r_rowBase <= w_rowBase0;
          r_x       <= {1'b0, r_x0};
          r_y       <= {1'b0, r_y0};
          r_clipped <= w_xClamp || w_yClamp || w_empty;
        end
        S_FILL: begin
          if (w_rowEnd) begin
            r_x <= {1'b0, r_x0};
            if (!w_lastRow) begin
              r_y       <= r_y + 11'd1;
              r_rowBase <= r_rowBase + FbWA;
            end
          end else begin
            r_x <= r_x + 11'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
